// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo counters: FSM encodings, wrap-counter
// width and its saturating increment.
package mod_counter_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;

  localparam int              WRAP_W   = 8;
  localparam logic [WRAP_W-1:0] WRAP_SAT = 8'hFF;

  function automatic logic [WRAP_W-1:0] wrap_sat_inc(input logic [WRAP_W-1:0] v);
    return (v == WRAP_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dff_rst.sv
// One-bit D flip-flop with synchronous active-high reset; building block
// for the count register so both counters share a structural style.
module dff_rst (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) q_o <= 1'b0;
    else       q_o <= d_i;
  end

endmodule

// File: rtl/mod_down_counter.sv
// Modulo-N down counter with start/stop FSM, clamped parallel load,
// terminal-count pulse and saturating wrap count.
// Define MOD_DOWN_ONESHOT_EN to stop at zero and return to IDLE instead of wrapping.
//
// state | meaning
// IDLE  | count held, waiting for start
// RUN   | counting down while en is high
module mod_down_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              running,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              running_q;
  logic              tc_q, tc_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic [WIDTH-1:0]  load_clamped;

  assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_CNT;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tc_d    = 1'b0;
    wraps_d = wraps_q;
    if (load) begin
      out_d = load_clamped;
      if (stop) state_d = ST_IDLE;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (start && (state_q == ST_IDLE)) begin
      state_d = ST_RUN;
      out_d   = MAX_CNT;
    end else if ((state_q == ST_RUN) && en) begin
      if (out_q != '0) begin
        out_d = out_q - 1'b1;
      end else begin
        tc_d    = 1'b1;
        wraps_d = wrap_sat_inc(wraps_q);
`ifdef MOD_DOWN_ONESHOT_EN
        out_d   = '0;
        state_d = ST_IDLE;
`else
        out_d   = MAX_CNT;
`endif
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt_bit
    dff_rst u_bit (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (out_d[i]),
      .q_o   (out_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      tc_q      <= 1'b0;
      wraps_q   <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      tc_q      <= tc_d;
      wraps_q   <= wraps_d;
    end
  end

  assign out     = out_q;
  assign running = running_q;
  assign tc      = tc_q;
  assign wraps   = wraps_q;

endmodule
